// File: rtl/via_n_m.sv
// via_n_m -- multi-port dependency point for NoC traffic models.
//
// Joins across NUM_IN sink ports, each buffered by a DEPTH-entry flit FIFO.
// One flit from every input (or nothing at all, with NODEP) produces one flit
// on every one of NUM_OUT source ports. Output destinations are either the
// return fields of the matching input head flit, or a rotating walk over the
// fixed DEST/DEST_VC list. `done` goes high once NUM_TESTS fires have been
// made and NUM_TESTS flits have been received on every input.
//
// Flit layout (MSB first):
//   return node | return VC | src node | dst node | dst VC | id[8] | counter[CW]
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   done     sticky test-complete flag
//   i_data   NUM_IN flits, port k at [k*WIDTH +: WIDTH]
//   i_valid  per-input valid
//   i_ready  per-input ready (FIFO not full; low in and just after reset)
//   o_data   NUM_OUT registered output flits
//   o_dest   per-output destination node
//   o_vc     per-output destination VC
//   o_valid  per-output one-cycle valid pulse
//   o_ready  per-output permission, sampled at the fire edge
//   seq_err  per-input sticky sequence error (only with VIA_SEQ_CHECK_EN)
//
// Build option: define VIA_SEQ_CHECK_EN to add the per-input, per-source
// counter sequence checker and the seq_err port.

module via_n_m #(
    parameter int                     N                = 16,
    parameter int                     NUM_VC           = 2,
    parameter int                     NUM_IN           = 2,
    parameter int                     NUM_OUT          = 2,
    parameter int                     WIDTH            = 32,
    parameter int                     DEPTH            = 4,
    parameter int                     NODE             = 15,
    parameter int                     ID               = 0,
    parameter bit                     NODEP            = 1'b0,
    parameter bit                     RETURN_TO_SENDER = !NODEP,
    parameter int                     NUM_DEST         = 4,
    // One 32-bit slot per list entry, entry 0 in the least significant slot.
    parameter logic [NUM_DEST*32-1:0] DEST             = {NUM_DEST{32'd1}},
    parameter logic [NUM_DEST*32-1:0] DEST_VC          = {NUM_DEST{32'd1}},
    parameter int                     NUM_TESTS        = 1000,
    localparam int                    NAW              = $clog2(N),
    localparam int                    VCW              = $clog2(NUM_VC)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     done,
    input  logic [NUM_IN*WIDTH-1:0]  i_data,
    input  logic [NUM_IN-1:0]        i_valid,
    output logic [NUM_IN-1:0]        i_ready,
    output logic [NUM_OUT*WIDTH-1:0] o_data,
    output logic [NUM_OUT*NAW-1:0]   o_dest,
    output logic [NUM_OUT*VCW-1:0]   o_vc,
    output logic [NUM_OUT-1:0]       o_valid,
    input  logic [NUM_OUT-1:0]       o_ready
`ifdef VIA_SEQ_CHECK_EN
    ,
    output logic [NUM_IN-1:0]        seq_err
`endif
);

    localparam int CW      = WIDTH - 3*NAW - 2*VCW - 8;
    localparam int PW      = $clog2(DEPTH);
    localparam int DPW     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int SRC_LSB = CW + 8 + VCW + NAW;

    generate
        if (CW < 1) begin : g_bad_width
            $error("via_n_m: WIDTH too small to hold the flit header");
        end
    endgenerate

    logic [WIDTH-1:0]  mem [NUM_IN][DEPTH];
    logic [PW-1:0]     rd_ptr [NUM_IN];
    logic [PW-1:0]     wr_ptr [NUM_IN];
    logic [PW:0]       count  [NUM_IN];
    logic [31:0]       rx_cnt [NUM_IN];
    logic [31:0]       rx_nxt [NUM_IN];
    logic [31:0]       fire_cnt;
    logic [31:0]       fire_nxt;
    logic [CW-1:0]     tx_cnt;
    logic [DPW-1:0]    ptr;
    logic              alive;
    logic [NUM_IN-1:0] push;
    logic [NUM_IN-1:0] pop;
    logic [NUM_IN-1:0] non_empty;
    logic              fire;
    logic              reached;
    logic [NAW-1:0]    dest_sel [NUM_OUT];
    logic [VCW-1:0]    vc_sel   [NUM_OUT];

    // alive holds i_ready low for the first cycle after reset release.
    always_comb begin
        non_empty = '0;
        i_ready   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            non_empty[k] = (count[k] != '0);
            i_ready[k]   = rst & alive & (count[k] != (PW+1)'(DEPTH));
        end
    end

    assign push = i_valid & i_ready;
    assign fire = (&o_ready) & ((&non_empty) | NODEP);
    assign pop  = {NUM_IN{fire}} & non_empty;

    // Heads are read before the pop that happens on the same edge.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            dest_sel[k] = '0;
            vc_sel[k]   = '0;
            if (RETURN_TO_SENDER) begin
                dest_sel[k] = mem[k % NUM_IN][rd_ptr[k % NUM_IN]][WIDTH-1 -: NAW];
                vc_sel[k]   = mem[k % NUM_IN][rd_ptr[k % NUM_IN]][WIDTH-NAW-1 -: VCW];
            end else begin
                dest_sel[k] = DEST[((int'(ptr) + k) % NUM_DEST)*32 +: NAW];
                vc_sel[k]   = DEST_VC[((int'(ptr) + k) % NUM_DEST)*32 +: VCW];
            end
        end
    end

    // done looks at post-edge counts so it rises together with the final fire.
    always_comb begin
        fire_nxt = fire_cnt;
        if (fire && (fire_cnt != '1))
            fire_nxt = fire_cnt + 32'd1;
        reached = (fire_nxt >= 32'(NUM_TESTS));
        for (int k = 0; k < NUM_IN; k++) begin
            rx_nxt[k] = rx_cnt[k];
            if (push[k] && (rx_cnt[k] != '1))
                rx_nxt[k] = rx_cnt[k] + 32'd1;
            if (rx_nxt[k] < 32'(NUM_TESTS))
                reached = 1'b0;
        end
    end

    // FIFO storage carries no reset; contents are dead once pointers clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (push[k])
                mem[k][wr_ptr[k]] <= i_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive    <= 1'b0;
            tx_cnt   <= '0;
            fire_cnt <= '0;
            ptr      <= '0;
            done     <= 1'b0;
            o_valid  <= '0;
            o_data   <= '0;
            o_dest   <= '0;
            o_vc     <= '0;
            for (int k = 0; k < NUM_IN; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                count[k]  <= '0;
                rx_cnt[k] <= '0;
            end
        end else begin
            alive    <= 1'b1;
            fire_cnt <= fire_nxt;
            done     <= done | reached;
            for (int k = 0; k < NUM_IN; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                count[k]  <= count[k] + (PW+1)'(push[k]) - (PW+1)'(pop[k]);
                rx_cnt[k] <= rx_nxt[k];
            end
            o_valid <= {NUM_OUT{fire}};
            if (fire) begin
                tx_cnt <= tx_cnt + CW'(1);
                ptr    <= (int'(ptr) == NUM_DEST-1) ? '0 : ptr + 1'b1;
                for (int k = 0; k < NUM_OUT; k++) begin
                    o_data[k*WIDTH +: WIDTH] <= {NAW'(NODE), VCW'(k % NUM_VC), NAW'(NODE),
                                                 dest_sel[k], vc_sel[k], 8'(ID),
                                                 tx_cnt + CW'(1)};
                    o_dest[k*NAW +: NAW]     <= dest_sel[k];
                    o_vc[k*VCW +: VCW]       <= vc_sel[k];
                end
            end
        end
    end

`ifdef VIA_SEQ_CHECK_EN
    // Expected next counter per (input, source node); resyncs after a miss.
    logic [CW-1:0] exp_seq [NUM_IN][N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err <= '0;
            for (int k = 0; k < NUM_IN; k++)
                for (int s = 0; s < N; s++)
                    exp_seq[k][s] <= CW'(1);
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (push[k]) begin
                    if (i_data[k*WIDTH +: CW] != exp_seq[k][i_data[k*WIDTH + SRC_LSB +: NAW]])
                        seq_err[k] <= 1'b1;
                    exp_seq[k][i_data[k*WIDTH + SRC_LSB +: NAW]] <= i_data[k*WIDTH +: CW] + CW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: doc/via_n_m.md
# via_n_m

Multi-port dependency point for NoC traffic simulation models. It generalises the single-input, single-output via to NUM_IN sink ports and NUM_OUT source ports, and gives each input a DEPTH-entry flit FIFO. It joins across all inputs: one flit from every input produces one flit on every output, with destinations either returned to the sender or taken round-robin from a fixed list. It sits between router ports in traffic-model testbenches and signals `done` after a programmable number of transactions.

## Interface
- N, 16, number of NoC nodes; NAW = $clog2(N)
- NUM_VC, 2, VCs per node; VCW = $clog2(NUM_VC)
- NUM_IN, 2, sink ports (≥1)
- NUM_OUT, 2, source ports (≥1)
- WIDTH, 32, flit width, shared by all ports
- DEPTH, 4, per-input FIFO entries (power of 2, ≥2)
- NODE, 15, router index of this via
- ID, 0, 8-bit via identifier
- NODEP, 0, 1: fire without waiting for inputs
- RETURN_TO_SENDER, !NODEP, 1: reply to the return field of the head flit
- NUM_DEST, 4, destination list length
- DEST[0:NUM_DEST-1], all 1, destination nodes
- DEST_VC[0:NUM_DEST-1], all 1, destination VCs
- NUM_TESTS, 1000, transaction target for `done`
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- done  out  1  sticky test-complete flag
- i_data  in  NUM_IN*WIDTH  input flits; port k occupies bits [k*WIDTH +: WIDTH]
- i_valid  in  NUM_IN  per-input valid
- i_ready  out  NUM_IN  per-input ready
- o_data  out  NUM_OUT*WIDTH  output flits
- o_dest  out  NUM_OUT*NAW  destination node
- o_vc  out  NUM_OUT*VCW  destination VC
- o_valid  out  NUM_OUT  per-output valid
- o_ready  in  NUM_OUT  per-output ready
- seq_err  out  NUM_IN  sequence error; exists only with VIA_SEQ_CHECK_EN

## Operation
- **Flit layout** (MSB first): return node (NAW), return VC (VCW), src node (NAW), dst node (NAW), dst VC (VCW), id (8), counter (CW).
  - CW = WIDTH − 3·NAW − 2·VCW − 8. Elaboration fails if CW < 1.
- **Input FIFOs:**
  - i_ready[k] = (count[k] < DEPTH).
  - Push when i_valid[k] && i_ready[k].
  - No overflow and no underflow are possible by construction.
- **Fire condition:** all o_ready high AND (every FIFO non-empty OR NODEP).
- **On fire:**
  - Each FIFO pops its head if non-empty. With NODEP=0, every FIFO is non-empty.
  - tx_cnt (CW bits, wraps) increments.
  - Output k flit = {NODE, k mod NUM_VC, NODE, dest_k, vc_k, ID, tx_cnt+1}.
- **Destination selection:**
  - RETURN_TO_SENDER=1: dest_k/vc_k = return fields of the head of input (k mod NUM_IN), sampled before the pop. Legal only with NODEP=0.
  - RETURN_TO_SENDER=0: dest_k = DEST[(ptr+k) mod NUM_DEST], same for DEST_VC. ptr advances by 1 mod NUM_DEST per fire and wraps NUM_DEST−1→0.
- **done:**
  - fire_cnt and each rx_cnt[k] are 32-bit saturating counters. rx_cnt[k] counts pushes.
  - done sets when fire_cnt ≥ NUM_TESTS and every rx_cnt[k] ≥ NUM_TESTS.
  - done holds until reset.

## Timing
- **Reset values:**
  - o_valid=0, o_data=0, o_dest=0, o_vc=0, done=0, seq_err=0.
  - i_ready=all 1 one cycle after reset deasserts. While in reset, i_ready=0 (gated by rst).
  - FIFOs empty; ptr=0; all counters 0.
- Outputs are registered. o_valid[k] pulses high for exactly one cycle, the cycle after a fire edge, and is 0 otherwise.
- Ready is a permission sampled at the fire edge. The consumer must accept any o_valid cycle.
- Input-to-output latency is 1 cycle: a flit pushed at edge t can cause a fire at edge t+1, with o_valid visible after t+1.
- **Simultaneous push and pop on one FIFO:** count is unchanged. A full FIFO has i_ready=0 in that cycle, so no push occurs with the pop (no bypass).
- Throughput is one fire per cycle while sustained.
- Reset asserted mid-operation clears all state asynchronously and discards in-flight FIFO contents.

## Configuration
- **VIA_SEQ_CHECK_EN defined:**
  - Each input tracks its expected counter per source node (N entries, CW bits, initially 1).
  - A pushed flit whose counter ≠ expected sets seq_err[k] (sticky). Expected is then resynced to counter+1.
- **VIA_SEQ_CHECK_EN undefined:** no checker logic and no seq_err port.

## Test plan
- Defaults, NODEP=0: push one flit on input 0 only → no o_valid. Then push on input 1 (return node 3, VC 1) → next cycle o_valid=2'b11, o_dest[0]=return of input 0, o_dest[1]=3, o_vc[1]=1, counter=1.
- Hold o_ready=0, push 4 flits per input → i_ready drops after the 4th. Release o_ready → 4 back-to-back fires, counters 1..4, i_ready returns.
- NODEP=1, RETURN_TO_SENDER=0, DEST={2,5,7,9}, no inputs → output 0 dest sequence 2,5,7,9,2; output 1 sequence 5,7,9,2,5.
- NUM_TESTS=10: drive 10 flits per input with o_ready=1 → done rises the cycle after the 10th fire and stays high.
- Assert rst mid-burst with FIFOs half full → all outputs zero immediately. After release, the first fire carries counter=1.
- VIA_SEQ_CHECK_EN: input 0 receives counters 1,2,4 from node 5 → seq_err[0] rises after the third push. A subsequent 5 raises no new error.
